// File: rtl/digitalclock_ctrl.sv
// Timekeeping and time-set controller for a six-digit HH:MM:SS clock.
// Packed-BCD time, one-second prescaler, key-driven set mode with blinking field.
module digitalclock_ctrl #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_mode,
  input  logic        key_inc,
  output logic [2:0]  DTube_en,
  output logic [2:0]  Twinkle_en,
  output logic [23:0] number_BCD,
  output logic        sec_pulse,
  output logic        set_active
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_H = 2'd1,
    ST_SET_M = 2'd2,
    ST_SET_S = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [23:0]   time_q, time_d;
  logic [2:0]    dtube_q, dtube_d;
  logic [2:0]    twinkle_q, twinkle_d;
  logic          sec_pulse_q, sec_pulse_d;
  logic          set_active_q, set_active_d;
  logic          key_mode_dly_q, key_mode_dly_d;
  logic          key_inc_dly_q, key_inc_dly_d;

  logic          mode_edge;
  logic          inc_edge;
  logic          tick;
  logic [8:0]    sec_inc;
  logic [8:0]    min_inc;
  logic [7:0]    hr_inc;

  // Two-digit BCD increment for 00..59; bit 8 is the carry out of 59.
  function automatic logic [8:0] inc_sixty(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    logic       carry;
    tens  = v[7:4];
    ones  = v[3:0];
    carry = 1'b0;
    if (ones == 4'd9) begin
      ones = 4'd0;
      if (tens == 4'd5) begin
        tens  = 4'd0;
        carry = 1'b1;
      end else begin
        tens = tens + 4'd1;
      end
    end else begin
      ones = ones + 4'd1;
    end
    return {carry, tens, ones};
  endfunction

  // Two-digit BCD increment for hours 00..23, wrapping to 00.
  function automatic logic [7:0] inc_hours(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = v[7:4];
    ones = v[3:0];
    if ((tens == 4'd2) && (ones == 4'd3)) begin
      tens = 4'd0;
      ones = 4'd0;
    end else if (ones == 4'd9) begin
      ones = 4'd0;
      tens = tens + 4'd1;
    end else begin
      ones = ones + 4'd1;
    end
    return {tens, ones};
  endfunction

  assign mode_edge = key_mode & ~key_mode_dly_q;
  assign inc_edge  = key_inc & ~key_inc_dly_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: mode key cycles RUN -> SET_H -> SET_M -> SET_S -> RUN
  always_comb begin
    state_d = state_q;
    if (mode_edge) begin
      case (state_q)
        ST_RUN:   state_d = ST_SET_H;
        ST_SET_H: state_d = ST_SET_M;
        ST_SET_M: state_d = ST_SET_S;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // State-derived outputs, registered alongside the state itself
  always_comb begin
    twinkle_d    = 3'b000;
    set_active_d = 1'b0;
    case (state_d)
      ST_SET_H: begin
        twinkle_d    = 3'b100;
        set_active_d = 1'b1;
      end
      ST_SET_M: begin
        twinkle_d    = 3'b010;
        set_active_d = 1'b1;
      end
      ST_SET_S: begin
        twinkle_d    = 3'b001;
        set_active_d = 1'b1;
      end
      default: begin
        twinkle_d    = 3'b000;
        set_active_d = 1'b0;
      end
    endcase
  end

  // Prescaler, time advance and field edit; a mode step freezes time for that edge
  always_comb begin
    presc_d        = '0;
    time_d         = time_q;
    tick           = 1'b0;
    dtube_d        = 3'b111;
    key_mode_dly_d = key_mode;
    key_inc_dly_d  = key_inc;
    sec_inc        = inc_sixty(time_q[7:0]);
    min_inc        = inc_sixty(time_q[15:8]);
    hr_inc         = inc_hours(time_q[23:16]);

    if ((state_q == ST_RUN) && !mode_edge) begin
      if (presc_q == PRESC_MAX) begin
        tick        = 1'b1;
        time_d[7:0] = sec_inc[7:0];
        if (sec_inc[8]) begin
          time_d[15:8] = min_inc[7:0];
          if (min_inc[8]) begin
            time_d[23:16] = hr_inc;
          end
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else if ((state_q != ST_RUN) && inc_edge && !mode_edge) begin
      case (state_q)
        ST_SET_H: time_d[23:16] = hr_inc;
        ST_SET_M: time_d[15:8]  = min_inc[7:0];
        default:  time_d[7:0]   = sec_inc[7:0];
      endcase
    end

    sec_pulse_d = tick;
  end

  // Datapath and output registers; key delay flops reset high to mask held keys
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q        <= '0;
      time_q         <= 24'h000000;
      dtube_q        <= 3'b000;
      twinkle_q      <= 3'b000;
      sec_pulse_q    <= 1'b0;
      set_active_q   <= 1'b0;
      key_mode_dly_q <= 1'b1;
      key_inc_dly_q  <= 1'b1;
    end else begin
      presc_q        <= presc_d;
      time_q         <= time_d;
      dtube_q        <= dtube_d;
      twinkle_q      <= twinkle_d;
      sec_pulse_q    <= sec_pulse_d;
      set_active_q   <= set_active_d;
      key_mode_dly_q <= key_mode_dly_d;
      key_inc_dly_q  <= key_inc_dly_d;
    end
  end

  assign DTube_en   = dtube_q;
  assign Twinkle_en = twinkle_q;
  assign number_BCD = time_q;
  assign sec_pulse  = sec_pulse_q;
  assign set_active = set_active_q;

endmodule

// File: tb/tb_digitalclock_ctrl.sv
// Self-checking bench for digitalclock_ctrl: seconds-of-day reference model,
// per-cycle compare, directed scenarios and a randomized key phase.
module tb_digitalclock_ctrl;

  localparam int unsigned TICK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_mode = 1'b0;
  logic        key_inc = 1'b0;
  logic [2:0]  DTube_en;
  logic [2:0]  Twinkle_en;
  logic [23:0] number_BCD;
  logic        sec_pulse;
  logic        set_active;

  digitalclock_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_mode   (key_mode),
    .key_inc    (key_inc),
    .DTube_en   (DTube_en),
    .Twinkle_en (Twinkle_en),
    .number_BCD (number_BCD),
    .sec_pulse  (sec_pulse),
    .set_active (set_active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time as seconds of day, mode as 0=RUN 1=SET_H 2=SET_M 3=SET_S
  int         m_state;
  int         m_presc;
  int         m_secs;
  bit         m_kmd;
  bit         m_kid;
  bit         m_pulse;
  logic [2:0] m_dtube;

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [23:0] bcd_of(input int secs);
    return {bcd2(secs / 3600), bcd2((secs / 60) % 60), bcd2(secs % 60)};
  endfunction

  function automatic logic [2:0] exp_twinkle(input int st);
    case (st)
      1:       return 3'b100;
      2:       return 3'b010;
      3:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    bit me;
    bit ie;
    int h;
    int mi;
    int s;
    if (rst) begin
      m_state = 0;
      m_presc = 0;
      m_secs  = 0;
      m_kmd   = 1'b1;
      m_kid   = 1'b1;
      m_pulse = 1'b0;
      m_dtube = 3'b000;
    end else begin
      me      = key_mode && !m_kmd;
      ie      = key_inc && !m_kid;
      m_kmd   = key_mode;
      m_kid   = key_inc;
      m_pulse = 1'b0;
      m_dtube = 3'b111;
      h  = m_secs / 3600;
      mi = (m_secs / 60) % 60;
      s  = m_secs % 60;
      if (me) begin
        m_state = (m_state + 1) % 4;
        m_presc = 0;
      end else if (m_state == 0) begin
        if (m_presc == TICK_DIV - 1) begin
          m_presc = 0;
          m_pulse = 1'b1;
          m_secs  = (m_secs + 1) % 86400;
        end else begin
          m_presc = m_presc + 1;
        end
      end else begin
        m_presc = 0;
        if (ie) begin
          case (m_state)
            1:       h  = (h + 1) % 24;
            2:       mi = (mi + 1) % 60;
            default: s  = (s + 1) % 60;
          endcase
          m_secs = h * 3600 + mi * 60 + s;
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      check("number_BCD", 32'(number_BCD), 32'(bcd_of(m_secs)));
      check("DTube_en",   32'(DTube_en),   32'(m_dtube));
      check("Twinkle_en", 32'(Twinkle_en), 32'(exp_twinkle(m_state)));
      check("sec_pulse",  32'(sec_pulse),  32'(m_pulse));
      check("set_active", 32'(set_active), 32'(m_state != 0));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_mode();
    @(posedge clk);
    #1 key_mode = 1'b1;
    @(posedge clk);
    #1 key_mode = 1'b0;
  endtask

  task automatic press_inc();
    @(posedge clk);
    #1 key_inc = 1'b1;
    @(posedge clk);
    #1 key_inc = 1'b0;
  endtask

  task automatic press_inc_n(input int n);
    for (int i = 0; i < n; i++) press_inc();
  endtask

  task automatic set_hours_to(input int tgt);
    press_inc_n((tgt - m_secs / 3600 + 24) % 24);
  endtask

  task automatic set_min_to(input int tgt);
    press_inc_n((tgt - (m_secs / 60) % 60 + 60) % 60);
  endtask

  task automatic set_sec_to(input int tgt);
    press_inc_n((tgt - m_secs % 60 + 60) % 60);
  endtask

  initial begin
    logic [23:0] exp_bcd;
    int          s0;

    // Reset and free run
    step(3);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int k = 1; k <= 244; k++) begin
      step(1);
      if (k == 1) check("dtube_after_release", 32'(DTube_en), 32'(3'b111));
      check("sec_pulse_cadence", 32'(sec_pulse), 32'((k % 4) == 0));
      if (k == 240) check("time_after_60_ticks", 32'(number_BCD), 32'h000100);
      if (k == 244) check("time_after_61_ticks", 32'(number_BCD), 32'h000101);
    end

    // Midnight rollover
    press_mode();
    set_hours_to(23);
    press_mode();
    set_min_to(59);
    press_mode();
    set_sec_to(59);
    check("set_235959", 32'(number_BCD), 32'h235959);
    press_mode();
    step(3);
    check("pre_midnight", 32'(number_BCD), 32'h235959);
    step(1);
    check("midnight", 32'(number_BCD), 32'h000000);
    check("midnight_pulse", 32'(sec_pulse), 32'd1);

    // Mode walk with a long dwell in SET_H
    press_mode();
    exp_bcd = bcd_of(m_secs);
    check("walk_twinkle_h", 32'(Twinkle_en), 32'(3'b100));
    check("walk_active_h",  32'(set_active), 32'd1);
    step(10 * TICK_DIV);
    check("walk_no_advance", 32'(number_BCD), 32'(exp_bcd));
    press_mode();
    check("walk_twinkle_m", 32'(Twinkle_en), 32'(3'b010));
    check("walk_active_m",  32'(set_active), 32'd1);
    press_mode();
    check("walk_twinkle_s", 32'(Twinkle_en), 32'(3'b001));
    check("walk_active_s",  32'(set_active), 32'd1);
    press_mode();
    check("walk_twinkle_run", 32'(Twinkle_en), 32'(3'b000));
    check("walk_active_run",  32'(set_active), 32'd0);

    // Field wrap without carry
    press_mode();
    set_hours_to(0);
    press_mode();
    set_min_to(59);
    press_mode();
    set_sec_to(0);
    press_mode();
    press_mode();
    press_mode();
    check("set_005900", 32'(number_BCD), 32'h005900);
    press_inc();
    check("min_wrap_no_carry", 32'(number_BCD), 32'h000000);
    press_mode();
    press_mode();
    press_mode();
    press_inc_n(23);
    check("hours_at_23", 32'(number_BCD[23:16]), 32'h23);
    press_inc();
    check("hours_wrap_00", 32'(number_BCD[23:16]), 32'h00);

    // Simultaneous mode and inc edges in SET_H
    @(posedge clk);
    #1 key_mode = 1'b1;
    key_inc = 1'b1;
    @(posedge clk);
    #1 key_mode = 1'b0;
    key_inc = 1'b0;
    check("simul_state_m", 32'(Twinkle_en), 32'(3'b010));
    check("simul_hours",   32'(number_BCD[23:16]), 32'h00);

    // Held inc key counts once
    press_mode();
    s0 = m_secs % 60;
    @(posedge clk);
    #1 key_inc = 1'b1;
    step(20);
    key_inc = 1'b0;
    check("held_inc_once", 32'(number_BCD[7:0]), 32'(bcd2((s0 + 1) % 60)));

    // inc edge in RUN is ignored
    press_mode();
    exp_bcd = bcd_of(m_secs);
    press_inc();
    check("inc_in_run", 32'(number_BCD), 32'(exp_bcd));

    // Asynchronous reset in SET_M at 12:34:56 with key_mode held through release
    press_mode();
    set_hours_to(12);
    press_mode();
    set_min_to(34);
    press_mode();
    set_sec_to(56);
    press_mode();
    press_mode();
    press_mode();
    check("set_123456", 32'(number_BCD), 32'h123456);
    check("pre_reset_twinkle", 32'(Twinkle_en), 32'(3'b010));
    #3 rst = 1'b1;
    #1;
    check("rst_number", 32'(number_BCD), 32'h000000);
    check("rst_dtube",  32'(DTube_en),   32'(3'b000));
    check("rst_twinkle", 32'(Twinkle_en), 32'(3'b000));
    check("rst_active", 32'(set_active), 32'd0);
    key_mode = 1'b1;
    step(3);
    @(negedge clk);
    #2 rst = 1'b0;
    step(1);
    check("post_rst_dtube",   32'(DTube_en),   32'(3'b111));
    check("post_rst_twinkle", 32'(Twinkle_en), 32'(3'b000));
    check("post_rst_active",  32'(set_active), 32'd0);
    check("post_rst_time",    32'(number_BCD), 32'h000000);
    step(2);
    check("held_mode_no_step", 32'(set_active), 32'd0);
    key_mode = 1'b0;

    // Randomized key activity
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      key_mode = ($urandom_range(0, 24) == 0);
      key_inc  = ($urandom_range(0, 2) == 0);
    end
    key_mode = 1'b0;
    key_inc  = 1'b0;
    step(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
